// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage register: default widths, bubble
// instruction, entry record shape and the occupancy states of the skid build.
package pipe_pkg;

  localparam int PC_W_DEF    = 16;
  localparam int INSTR_W_DEF = 16;
  localparam logic [INSTR_W_DEF-1:0] NOP_INSTR_DEF = 16'h0000;

  typedef struct packed {
    logic                   valid;
    logic [PC_W_DEF-1:0]    pc;
    logic [INSTR_W_DEF-1:0] instr;
  } entry_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } stage_state_e;

  function automatic logic [1:0] occ_count(input logic h_valid, input logic s_valid);
    return {1'b0, h_valid} + {1'b0, s_valid};
  endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle between upstream producer, stage register and downstream
// consumer; the stage uses the slave view, the surrounding logic the master view.
interface pipe_stage_reg_if
  import pipe_pkg::*;
#(
  parameter int PC_W    = PC_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
);

  logic               in_valid;
  logic               in_ready;
  logic [PC_W-1:0]    in_pc;
  logic [INSTR_W-1:0] in_instr;
  logic               flush;
  logic               out_valid;
  logic               out_ready;
  logic [PC_W-1:0]    out_pc;
  logic [INSTR_W-1:0] out_instr;
  logic [1:0]         occupancy;

  modport master (
    output in_valid, in_pc, in_instr, flush, out_ready,
    input  in_ready, out_valid, out_pc, out_instr, occupancy
  );

  modport slave (
    input  in_valid, in_pc, in_instr, flush, out_ready,
    output in_ready, out_valid, out_pc, out_instr, occupancy
  );

endinterface

// File: rtl/pipe_entry_reg.sv
// One held pipeline entry: load a new {pc, instr}, turn into a bubble while
// keeping the last PC, or hold.
module pipe_entry_reg
  import pipe_pkg::*;
#(
  parameter int PC_W    = PC_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_INSTR_DEF)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               clear,
  input  logic [PC_W-1:0]    d_pc,
  input  logic [INSTR_W-1:0] d_instr,
  output logic               valid,
  output logic [PC_W-1:0]    pc,
  output logic [INSTR_W-1:0] instr
);

  logic               valid_r;
  logic [PC_W-1:0]    pc_r;
  logic [INSTR_W-1:0] instr_r;

  // Entry storage; clear wins over load and leaves pc_r untouched.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_r <= 1'b0;
      pc_r    <= {PC_W{1'b0}};
      instr_r <= NOP_INSTR;
    end else if (clear) begin
      valid_r <= 1'b0;
      instr_r <= NOP_INSTR;
    end else if (load) begin
      valid_r <= 1'b1;
      pc_r    <= d_pc;
      instr_r <= d_instr;
    end
  end

  assign valid = valid_r;
  assign pc    = pc_r;
  assign instr = instr_r;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with one-cycle latency; SKID=1 gives a two-entry
// skid buffer with registered in_ready, SKID=0 a single entry.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int PC_W    = PC_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_INSTR_DEF),
  parameter int SKID    = 1
) (
  input logic             clk,
  input logic             rst,
  pipe_stage_reg_if.slave bus
);

  logic               in_xfer_s;
  logic               out_xfer_s;
  logic               h_valid_s;
  logic [PC_W-1:0]    h_pc_s;
  logic [INSTR_W-1:0] h_instr_s;
  logic               h_load_s;
  logic               h_clear_s;
  logic [PC_W-1:0]    h_d_pc_s;
  logic [INSTR_W-1:0] h_d_instr_s;
  logic               s_valid_s;

  assign in_xfer_s  = bus.in_valid & bus.in_ready & ~bus.flush;
  assign out_xfer_s = h_valid_s & bus.out_ready;

  pipe_entry_reg #(
    .PC_W(PC_W), .INSTR_W(INSTR_W), .NOP_INSTR(NOP_INSTR)
  ) u_head (
    .clk(clk), .rst(rst), .load(h_load_s), .clear(h_clear_s),
    .d_pc(h_d_pc_s), .d_instr(h_d_instr_s),
    .valid(h_valid_s), .pc(h_pc_s), .instr(h_instr_s)
  );

  // Outputs come straight from the head registers.
  assign bus.out_valid = h_valid_s;
  assign bus.out_pc    = h_pc_s;
  assign bus.out_instr = h_instr_s;
  assign bus.occupancy = occ_count(h_valid_s, s_valid_s);

  generate
    if (SKID != 0) begin : g_skid
      stage_state_e       state_r;
      stage_state_e       state_next_s;
      logic               in_ready_r;
      logic               s_load_s;
      logic               s_clear_s;
      logic               h_from_s_s;
      logic [PC_W-1:0]    s_pc_s;
      logic [INSTR_W-1:0] s_instr_s;

      pipe_entry_reg #(
        .PC_W(PC_W), .INSTR_W(INSTR_W), .NOP_INSTR(NOP_INSTR)
      ) u_skid (
        .clk(clk), .rst(rst), .load(s_load_s), .clear(s_clear_s),
        .d_pc(bus.in_pc), .d_instr(bus.in_instr),
        .valid(s_valid_s), .pc(s_pc_s), .instr(s_instr_s)
      );

      // State register; in_ready is precomputed so it is a flop output.
      always_ff @(posedge clk) begin
        if (!rst) begin
          state_r    <= ST_EMPTY;
          in_ready_r <= 1'b1;
        end else begin
          state_r    <= state_next_s;
          in_ready_r <= (state_next_s != ST_FULL);
        end
      end

      // Next-state logic; flush empties the stage regardless of transfers.
      always_comb begin
        state_next_s = state_r;
        if (bus.flush) begin
          state_next_s = ST_EMPTY;
        end else begin
          case (state_r)
            ST_EMPTY: state_next_s = in_xfer_s ? ST_ONE : ST_EMPTY;
            ST_ONE: begin
              if (in_xfer_s && !out_xfer_s) begin
                state_next_s = ST_FULL;
              end else if (!in_xfer_s && out_xfer_s) begin
                state_next_s = ST_EMPTY;
              end else begin
                state_next_s = ST_ONE;
              end
            end
            ST_FULL:  state_next_s = out_xfer_s ? ST_ONE : ST_FULL;
            default:  state_next_s = ST_EMPTY;
          endcase
        end
      end

      // Entry controls: head refills from skid when FULL drains.
      always_comb begin
        h_load_s   = 1'b0;
        h_clear_s  = 1'b0;
        h_from_s_s = 1'b0;
        s_load_s   = 1'b0;
        s_clear_s  = 1'b0;
        if (bus.flush) begin
          h_clear_s = 1'b1;
          s_clear_s = 1'b1;
        end else begin
          case (state_r)
            ST_EMPTY: h_load_s = in_xfer_s;
            ST_ONE: begin
              if (in_xfer_s && out_xfer_s) begin
                h_load_s = 1'b1;
              end else if (in_xfer_s) begin
                s_load_s = 1'b1;
              end else if (out_xfer_s) begin
                h_clear_s = 1'b1;
              end else begin
                h_load_s = 1'b0;
              end
            end
            ST_FULL: begin
              if (out_xfer_s) begin
                h_load_s   = 1'b1;
                h_from_s_s = 1'b1;
                s_clear_s  = 1'b1;
              end else begin
                h_load_s = 1'b0;
              end
            end
            default: h_clear_s = 1'b1;
          endcase
        end
      end

      assign bus.in_ready = in_ready_r;
      assign h_d_pc_s     = h_from_s_s ? s_pc_s : bus.in_pc;
      assign h_d_instr_s  = h_from_s_s ? s_instr_s : bus.in_instr;
    end else begin : g_single
      assign s_valid_s    = 1'b0;
      assign bus.in_ready = ~h_valid_s | bus.out_ready;
      assign h_d_pc_s     = bus.in_pc;
      assign h_d_instr_s  = bus.in_instr;

      // Single entry: a new input replaces the head even while it drains.
      always_comb begin
        h_load_s  = 1'b0;
        h_clear_s = 1'b0;
        if (bus.flush) begin
          h_clear_s = 1'b1;
        end else if (in_xfer_s) begin
          h_load_s = 1'b1;
        end else if (out_xfer_s) begin
          h_clear_s = 1'b1;
        end else begin
          h_load_s = 1'b0;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed vector tables for the skid and single-entry
// builds plus random traffic checked against queue-based reference models.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam logic [15:0] NOP = 16'h0000;

  typedef struct {
    logic        rst;
    logic        iv;
    logic [15:0] pc;
    logic [15:0] instr;
    logic        fl;
    logic        ordy;
    logic        e_ov;
    logic [15:0] e_pc;
    logic [15:0] e_instr;
    logic [1:0]  e_occ;
    logic        e_ir;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_pc;
  logic [15:0] in_instr;
  logic        flush;
  logic        out_ready;

  int checks = 0;
  int fails  = 0;

  vec_t tab1[$];
  vec_t tab0[$];

  entry_t      q1[$];
  entry_t      q0[$];
  logic [15:0] last1;
  logic [15:0] last0;
  logic        rdy1;

  always #5 clk = ~clk;

  pipe_stage_reg_if #(.PC_W(16), .INSTR_W(16)) bus1 ();
  pipe_stage_reg_if #(.PC_W(16), .INSTR_W(16)) bus0 ();

  assign bus1.in_valid  = in_valid;
  assign bus1.in_pc     = in_pc;
  assign bus1.in_instr  = in_instr;
  assign bus1.flush     = flush;
  assign bus1.out_ready = out_ready;
  assign bus0.in_valid  = in_valid;
  assign bus0.in_pc     = in_pc;
  assign bus0.in_instr  = in_instr;
  assign bus0.flush     = flush;
  assign bus0.out_ready = out_ready;

  pipe_stage_reg #(.PC_W(16), .INSTR_W(16), .NOP_INSTR(NOP), .SKID(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );
  pipe_stage_reg #(.PC_W(16), .INSTR_W(16), .NOP_INSTR(NOP), .SKID(0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0)
  );

  function automatic vec_t mk(input logic r, input logic iv, input logic [15:0] pc,
                              input logic [15:0] ins, input logic fl, input logic ordy,
                              input logic eov, input logic [15:0] epc,
                              input logic [15:0] eins, input logic [1:0] eocc,
                              input logic eir);
    vec_t v;
    v.rst = r; v.iv = iv; v.pc = pc; v.instr = ins; v.fl = fl; v.ordy = ordy;
    v.e_ov = eov; v.e_pc = epc; v.e_instr = eins; v.e_occ = eocc; v.e_ir = eir;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_outs(input bit sel, input string tag, input logic eov,
                            input logic [15:0] epc, input logic [15:0] eins,
                            input logic [1:0] eocc, input logic eir);
    if (sel) begin
      check({tag, ".out_valid"}, 32'(bus1.out_valid), 32'(eov));
      check({tag, ".out_pc"},    32'(bus1.out_pc),    32'(epc));
      check({tag, ".out_instr"}, 32'(bus1.out_instr), 32'(eins));
      check({tag, ".occupancy"}, 32'(bus1.occupancy), 32'(eocc));
      check({tag, ".in_ready"},  32'(bus1.in_ready),  32'(eir));
    end else begin
      check({tag, ".out_valid"}, 32'(bus0.out_valid), 32'(eov));
      check({tag, ".out_pc"},    32'(bus0.out_pc),    32'(epc));
      check({tag, ".out_instr"}, 32'(bus0.out_instr), 32'(eins));
      check({tag, ".occupancy"}, 32'(bus0.occupancy), 32'(eocc));
      check({tag, ".in_ready"},  32'(bus0.in_ready),  32'(eir));
    end
  endtask

  task automatic drive(input logic r, input logic iv, input logic [15:0] pc,
                       input logic [15:0] ins, input logic fl, input logic ordy);
    rst = r; in_valid = iv; in_pc = pc; in_instr = ins; flush = fl; out_ready = ordy;
  endtask

  task automatic run_vec(input vec_t v, input bit sel, input string tag);
    @(negedge clk);
    drive(v.rst, v.iv, v.pc, v.instr, v.fl, v.ordy);
    #1;
    check_outs(sel, tag, v.e_ov, v.e_pc, v.e_instr, v.e_occ, v.e_ir);
  endtask

  task automatic hold_reset(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      drive(1'b0, 1'b1, 16'h00AA, 16'hBEEF, 1'b0, 1'b1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        acc;
    logic        pop;
    logic [15:0] epc;
    logic [15:0] eins;

    // Skid build: reset, stream, backpressure, flush, reset mid-FULL.
    tab1.push_back(mk(1, 1, 16'h00AA, 16'hBEEF, 0, 1,  0, 16'h0000, NOP,      0, 1));
    tab1.push_back(mk(1, 1, 16'h0000, 16'hA001, 0, 1,  1, 16'h00AA, 16'hBEEF, 1, 1));
    tab1.push_back(mk(1, 1, 16'h0002, 16'hA002, 0, 1,  1, 16'h0000, 16'hA001, 1, 1));
    tab1.push_back(mk(1, 1, 16'h0004, 16'hA003, 0, 1,  1, 16'h0002, 16'hA002, 1, 1));
    tab1.push_back(mk(1, 1, 16'h0006, 16'hA004, 0, 1,  1, 16'h0004, 16'hA003, 1, 1));
    tab1.push_back(mk(1, 0, 16'h0000, 16'h0000, 0, 1,  1, 16'h0006, 16'hA004, 1, 1));
    tab1.push_back(mk(1, 0, 16'h0000, 16'h0000, 0, 1,  0, 16'h0006, NOP,      0, 1));
    tab1.push_back(mk(1, 1, 16'h1111, 16'hB001, 0, 0,  0, 16'h0006, NOP,      0, 1));
    tab1.push_back(mk(1, 1, 16'h2222, 16'hB002, 0, 0,  1, 16'h1111, 16'hB001, 1, 1));
    tab1.push_back(mk(1, 1, 16'h3333, 16'hB003, 0, 0,  1, 16'h1111, 16'hB001, 2, 0));
    tab1.push_back(mk(1, 1, 16'h3333, 16'hB003, 0, 0,  1, 16'h1111, 16'hB001, 2, 0));
    tab1.push_back(mk(1, 1, 16'h3333, 16'hB003, 0, 1,  1, 16'h1111, 16'hB001, 2, 0));
    tab1.push_back(mk(1, 1, 16'h3333, 16'hB003, 0, 1,  1, 16'h2222, 16'hB002, 1, 1));
    tab1.push_back(mk(1, 0, 16'h0000, 16'h0000, 0, 1,  1, 16'h3333, 16'hB003, 1, 1));
    tab1.push_back(mk(1, 0, 16'h0000, 16'h0000, 0, 0,  0, 16'h3333, NOP,      0, 1));
    tab1.push_back(mk(1, 1, 16'h0010, 16'hC001, 0, 0,  0, 16'h3333, NOP,      0, 1));
    tab1.push_back(mk(1, 1, 16'h0020, 16'hC002, 0, 0,  1, 16'h0010, 16'hC001, 1, 1));
    tab1.push_back(mk(1, 1, 16'h0040, 16'hC004, 1, 1,  1, 16'h0010, 16'hC001, 2, 0));
    tab1.push_back(mk(1, 0, 16'h0000, 16'h0000, 0, 1,  0, 16'h0010, NOP,      0, 1));
    tab1.push_back(mk(1, 1, 16'h0050, 16'hD005, 0, 0,  0, 16'h0010, NOP,      0, 1));
    tab1.push_back(mk(1, 1, 16'h0060, 16'hD006, 1, 1,  1, 16'h0050, 16'hD005, 1, 1));
    tab1.push_back(mk(1, 0, 16'h0000, 16'h0000, 0, 0,  0, 16'h0050, NOP,      0, 1));
    tab1.push_back(mk(1, 1, 16'h0070, 16'hE007, 0, 0,  0, 16'h0050, NOP,      0, 1));
    tab1.push_back(mk(1, 1, 16'h0080, 16'hE008, 0, 0,  1, 16'h0070, 16'hE007, 1, 1));
    tab1.push_back(mk(0, 1, 16'h0090, 16'hE009, 0, 1,  1, 16'h0070, 16'hE007, 2, 0));
    tab1.push_back(mk(1, 1, 16'h00A0, 16'hE00A, 0, 1,  0, 16'h0000, NOP,      0, 1));
    tab1.push_back(mk(1, 0, 16'h0000, 16'h0000, 0, 1,  1, 16'h00A0, 16'hE00A, 1, 1));
    tab1.push_back(mk(1, 0, 16'h0000, 16'h0000, 0, 1,  0, 16'h00A0, NOP,      0, 1));

    // Single-entry build: stall, replace-on-drain, flush, pop to empty.
    tab0.push_back(mk(1, 1, 16'h0100, 16'hF001, 0, 0,  0, 16'h0000, NOP,      0, 1));
    tab0.push_back(mk(1, 1, 16'h0200, 16'hF002, 0, 0,  1, 16'h0100, 16'hF001, 1, 0));
    tab0.push_back(mk(1, 1, 16'h0200, 16'hF002, 0, 1,  1, 16'h0100, 16'hF001, 1, 1));
    tab0.push_back(mk(1, 0, 16'h0000, 16'h0000, 0, 0,  1, 16'h0200, 16'hF002, 1, 0));
    tab0.push_back(mk(1, 1, 16'h0300, 16'hF003, 1, 1,  1, 16'h0200, 16'hF002, 1, 1));
    tab0.push_back(mk(1, 0, 16'h0000, 16'h0000, 0, 0,  0, 16'h0200, NOP,      0, 1));
    tab0.push_back(mk(1, 1, 16'h0400, 16'hF004, 0, 1,  0, 16'h0200, NOP,      0, 1));
    tab0.push_back(mk(1, 0, 16'h0000, 16'h0000, 0, 1,  1, 16'h0400, 16'hF004, 1, 1));
    tab0.push_back(mk(1, 0, 16'h0000, 16'h0000, 0, 0,  0, 16'h0400, NOP,      0, 1));

    hold_reset(2);
    for (int i = 0; i < tab1.size(); i++) run_vec(tab1[i], 1'b1, $sformatf("skid1_v%0d", i));

    hold_reset(1);
    q1.delete(); q0.delete();
    last1 = 16'h0000; last0 = 16'h0000; rdy1 = 1'b1;

    // Random traffic against queue models (capacity 2 vs 1).
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      drive(logic'($urandom_range(0, 39) != 0), logic'($urandom_range(0, 1)),
            16'($urandom), 16'($urandom), logic'($urandom_range(0, 15) == 0),
            logic'($urandom_range(0, 1)));
      #1;
      epc  = (q1.size() != 0) ? q1[0].pc : last1;
      eins = (q1.size() != 0) ? q1[0].instr : NOP;
      check_outs(1'b1, $sformatf("rand1_c%0d", i), q1.size() != 0, epc, eins,
                 2'(q1.size()), rdy1);
      epc  = (q0.size() != 0) ? q0[0].pc : last0;
      eins = (q0.size() != 0) ? q0[0].instr : NOP;
      check_outs(1'b0, $sformatf("rand0_c%0d", i), q0.size() != 0, epc, eins,
                 2'(q0.size()), (q0.size() == 0) || out_ready);

      if (!rst) begin
        q1.delete(); last1 = 16'h0000; rdy1 = 1'b1;
      end else if (flush) begin
        q1.delete(); rdy1 = 1'b1;
      end else begin
        acc = in_valid && rdy1;
        pop = (q1.size() != 0) && out_ready;
        if (pop) void'(q1.pop_front());
        if (acc) q1.push_back('{1'b1, in_pc, in_instr});
        rdy1 = (q1.size() < 2);
      end
      if (q1.size() != 0) last1 = q1[0].pc;

      if (!rst) begin
        q0.delete(); last0 = 16'h0000;
      end else if (flush) begin
        q0.delete();
      end else begin
        acc = in_valid && ((q0.size() == 0) || out_ready);
        pop = (q0.size() != 0) && out_ready;
        if (pop) void'(q0.pop_front());
        if (acc) q0.push_back('{1'b1, in_pc, in_instr});
      end
      if (q0.size() != 0) last0 = q0[0].pc;
    end

    hold_reset(1);
    for (int i = 0; i < tab0.size(); i++) run_vec(tab0[i], 1'b0, $sformatf("skid0_v%0d", i));

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter PC_W, default 16, program-counter field width.
REQ-002 SHALL have parameter INSTR_W, default 16, instruction field width.
REQ-003 SHALL have parameter NOP_INSTR, default all-zero INSTR_W, instruction presented when the stage holds a bubble.
REQ-004 SHALL have parameter SKID, default 1: 1 = two-entry skid stage with registered in_ready; 0 = single-entry stage.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-low.
REQ-007 in_valid  input  1  upstream offers in_pc/in_instr.
REQ-008 in_ready  output  1  stage accepts this cycle.
REQ-009 in_pc  input  PC_W  upstream PC.
REQ-010 in_instr  input  INSTR_W  upstream instruction.
REQ-011 flush  input  1  discard all held and incoming entries.
REQ-012 out_valid  output  1  out_pc/out_instr hold a real entry.
REQ-013 out_ready  input  1  downstream consumes this cycle.
REQ-014 out_pc  output  PC_W  head-entry PC.
REQ-015 out_instr  output  INSTR_W  head-entry instruction, NOP_INSTR when out_valid=0.
REQ-016 occupancy  output  2  entries held (0..2; max 1 when SKID=0).

Function
REQ-017 Input transfer SHALL occur iff in_valid & in_ready & ~flush; output transfer iff out_valid & out_ready.
REQ-018 Entries SHALL leave in arrival order; no duplication, no loss except by flush.
REQ-019 Latency SHALL be one cycle: an entry accepted into an empty stage appears on out_* the next cycle.
REQ-020 SKID=1: state is head (H) and skid (S) entries; states EMPTY(0), ONE(H), FULL(H+S).
REQ-021 SKID=1: in_ready SHALL be a register output equal to ~S.valid (1 in EMPTY and ONE, 0 in FULL).
REQ-022 EMPTY + input transfer -> ONE (entry into H).
REQ-023 ONE + input only -> FULL (entry into S); ONE + output only -> EMPTY; ONE + both -> ONE (new entry into H).
REQ-024 FULL + output transfer -> ONE (S moves to H, S cleared); FULL without output -> FULL, all held values stable.
REQ-025 SKID=0: single H entry; in_ready = ~H.valid | out_ready (combinational); simultaneous in/out transfer replaces H.
REQ-026 flush SHALL, next cycle, clear both valids, set out_instr=NOP_INSTR, occupancy=0, in_ready=1; flush overrides simultaneous input and output transfers.
REQ-027 On flush and on pop-to-EMPTY, out_pc SHALL retain its last value (bubble carries last PC).
REQ-028 occupancy SHALL equal H.valid + S.valid every cycle.
REQ-029 out_* SHALL be driven directly from H registers, no combinational path from in_* to out_*.

Reset
REQ-030 When rst=0 at a rising edge: H.valid=S.valid=0, out_pc=0, out_instr=NOP_INSTR, occupancy=0, in_ready=1 (SKID=1).
REQ-031 Reset SHALL override flush and all transfers in the same cycle; held entries are dropped.
REQ-032 First transfer accepted on the first edge after rst returns to 1.

Structure
REQ-033 Entry record {valid, pc, instr} type and NOP_INSTR default SHALL live in shared package pipe_pkg.
REQ-034 One sub-module, pipe_entry_reg (one entry: load, clear-to-bubble, hold), instantiated for H and, when SKID=1, for S via generate.
REQ-035 Target 120-400 lines RTL total.

Verification
REQ-036 Reset: rst=0 two cycles, in_valid=1 -> out_valid=0, out_instr=NOP_INSTR, occupancy=0, in_ready=1 after release.
REQ-037 Stream: out_ready=1, send pc 0x0000..0x0006 step 2, instr 0xA001..0xA004 back-to-back -> same sequence on out_*, one-cycle latency, no gaps.
REQ-038 Backpressure: out_ready=0, send 0x1111 then 0x2222 -> occupancy=2, in_ready=0, 0x3333 held upstream; raise out_ready -> 0x1111, 0x2222, 0x3333 in order.
REQ-039 Flush in FULL with in_valid=1 (pc 0x0040) -> next cycle occupancy=0, out_valid=0, out_instr=NOP_INSTR, out_pc unchanged, 0x0040 never emitted.
REQ-040 Reset mid-FULL with out_ready=1 -> no entry emitted, state as REQ-030.
REQ-041 SKID=0 build: out_ready=0 with H full -> in_ready=0; out_ready=1 and in_valid=1 same cycle -> H replaced, occupancy stays 1.
